// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between a UART receiver, the RX FIFO and its consumer.
// The slave modport is the FIFO side; the master modport drives bytes and pops.
interface uart_rx_fifo_if #(
  parameter int unsigned CNT_W = 5
);
  logic             uart_rx_valid;
  logic [7:0]       uart_rx_data;
  logic             uart_rx_break;
  logic             fifo_ready;
  logic             fifo_valid;
  logic [7:0]       fifo_data;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             overflow;
  logic             break_seen;
  logic             flag_clr;

  modport master (
    output uart_rx_valid,
    output uart_rx_data,
    output uart_rx_break,
    output fifo_ready,
    output flag_clr,
    input  fifo_valid,
    input  fifo_data,
    input  fifo_count,
    input  fifo_full,
    input  overflow,
    input  break_seen
  );

  modport slave (
    input  uart_rx_valid,
    input  uart_rx_data,
    input  uart_rx_break,
    input  fifo_ready,
    input  flag_clr,
    output fifo_valid,
    output fifo_data,
    output fifo_count,
    output fifo_full,
    output overflow,
    output break_seen
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind a UART receiver, with sticky overflow/break flags.
// Define UART_RX_FIFO_BREAK_FLUSH_EN to make a BREAK strobe flush the FIFO.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input logic           clk,
  input logic           resetn,
  uart_rx_fifo_if.slave bus
);

  localparam int unsigned      AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             break_q, break_d;

  logic empty, full, pop, push, flush, wr_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // fifo_ready is only honoured while there is something to pop.
  assign pop   = ~empty & bus.fifo_ready;
  assign push  = bus.uart_rx_valid & (~full | pop);

`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
  assign flush = bus.uart_rx_break;
`else
  assign flush = 1'b0;
`endif

  // A byte arriving alongside a flushing BREAK is discarded.
  assign wr_en = push & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Set beats clear when both happen in the same cycle.
  assign overflow_d = (bus.uart_rx_valid & ~push) | (overflow_q & ~bus.flag_clr);
  assign break_d    = bus.uart_rx_break | (break_q & ~bus.flag_clr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      break_q    <= break_d;
    end
  end

  // Storage is not reset; the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.uart_rx_data;
  end

  assign bus.fifo_valid = ~empty;
  assign bus.fifo_full  = full;
  assign bus.fifo_count = count_q;
  assign bus.fifo_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.overflow   = overflow_q;
  assign bus.break_seen = break_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue model predicts every byte and flag,
// and each pop compares the DUT head byte against the front of the queue.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 5;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.CNT_W(CNT_W)) bus ();

  uart_rx_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  logic [7:0] exp_q[$];
  logic       m_ovf;
  logic       m_brk;
  int         n_tests;
  int         n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(bus.fifo_count), 32'(exp_q.size()));
    check({tag, "_valid"}, 32'(bus.fifo_valid), 32'(exp_q.size() != 0));
    check({tag, "_full"},  32'(bus.fifo_full),  32'(exp_q.size() == DEPTH));
    check({tag, "_ovf"},   32'(bus.overflow),   32'(m_ovf));
    check({tag, "_brk"},   32'(bus.break_seen), 32'(m_brk));
  endtask

  // One clock: predict, compare any popped head byte, advance, then check state.
  task automatic step(input string tag);
    bit         pop, push, ovf_set;
    logic [7:0] din;
    pop     = bus.fifo_ready && (exp_q.size() > 0);
    push    = bus.uart_rx_valid && ((exp_q.size() < DEPTH) || pop);
    ovf_set = bus.uart_rx_valid && !push;
    din     = bus.uart_rx_data;
    if (pop) check({tag, "_data"}, 32'(bus.fifo_data), 32'(exp_q[0]));
    @(posedge clk);
    #1;
    if (pop) void'(exp_q.pop_front());
`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
    if (bus.uart_rx_break) begin
      exp_q.delete();
      push = 1'b0;
    end
`endif
    if (push) exp_q.push_back(din);
    m_ovf = ovf_set || (m_ovf && !bus.flag_clr);
    m_brk = bus.uart_rx_break || (m_brk && !bus.flag_clr);
    check_state(tag);
    bus.uart_rx_valid = 1'b0;
    bus.uart_rx_break = 1'b0;
    bus.flag_clr      = 1'b0;
    bus.uart_rx_data  = 8'($urandom);
  endtask

  task automatic push_byte(input string tag, input logic [7:0] d);
    bus.uart_rx_valid = 1'b1;
    bus.uart_rx_data  = d;
    step(tag);
  endtask

  task automatic drain(input string tag);
    bus.fifo_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 4 && exp_q.size() > 0; i++) step(tag);
    check({tag, "_empty_valid"}, 32'(bus.fifo_valid), 32'd0);
    check({tag, "_empty_data"},  32'(bus.fifo_data),  32'h00);
    bus.fifo_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests           = 0;
    n_fail            = 0;
    m_ovf             = 1'b0;
    m_brk             = 1'b0;
    bus.uart_rx_valid = 1'b0;
    bus.uart_rx_data  = 8'h00;
    bus.uart_rx_break = 1'b0;
    bus.fifo_ready    = 1'b0;
    bus.flag_clr      = 1'b0;

    #1;
    check_state("reset");
    check("reset_data", 32'(bus.fifo_data), 32'h00);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Three bytes held, then drained; first byte visible right after its edge.
    push_byte("p3", 8'hA5);
    check("latency", 32'(bus.fifo_data), 32'hA5);
    push_byte("p3", 8'h3C);
    push_byte("p3", 8'hFF);
    check("p3_count3", 32'(bus.fifo_count), 32'd3);
    drain("p3_drain");

    // Ready high while empty must not pop the byte being pushed.
    bus.fifo_ready = 1'b1;
    push_byte("empty_rdy", 8'h5A);
    check("empty_rdy_count", 32'(bus.fifo_count), 32'd1);
    drain("empty_rdy_drain");

    // Overfill by one: last byte dropped, overflow sticky.
    for (int i = 0; i <= DEPTH; i++) push_byte("fill17", 8'(i));
    check("fill17_full", 32'(bus.fifo_full), 32'd1);
    check("fill17_ovf",  32'(bus.overflow),  32'd1);
    drain("fill17_drain");
    check("fill17_ovf_sticky", 32'(bus.overflow), 32'd1);
    bus.flag_clr = 1'b1;
    step("clr_ovf");
    check("clr_ovf_val", 32'(bus.overflow), 32'd0);

    // Full with simultaneous push and pop: write accepted, no overflow.
    for (int i = 0; i < DEPTH; i++) push_byte("fill16", 8'(8'h20 + i));
    bus.fifo_ready = 1'b1;
    push_byte("full_pp", 8'h55);
    check("full_pp_count", 32'(bus.fifo_count), 32'd16);
    check("full_pp_ovf",   32'(bus.overflow),   32'd0);
    drain("full_pp_drain");

    // Stream 40 bytes with ready toggling; pointers wrap past DEPTH twice.
    for (int i = 0; i < 80; i++) begin
      bus.fifo_ready = i[0];
      if (!i[0]) begin
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = 8'(8'h40 + i / 2);
      end
      step("stream");
    end
    check("stream_ovf", 32'(bus.overflow), 32'd0);
    drain("stream_drain");

    // Push and pop at count==1 keeps count at 1.
    push_byte("c1_seed", 8'h61);
    bus.fifo_ready = 1'b1;
    push_byte("c1_pp", 8'h62);
    check("c1_pp_count", 32'(bus.fifo_count), 32'd1);
    drain("c1_drain");

    // BREAK with five bytes stored.
    for (int i = 0; i < 5; i++) push_byte("brk_fill", 8'(8'h70 + i));
    bus.uart_rx_break = 1'b1;
    step("brk");
`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
    check("brk_count", 32'(bus.fifo_count), 32'd0);
`else
    check("brk_count", 32'(bus.fifo_count), 32'd5);
`endif
    check("brk_seen", 32'(bus.break_seen), 32'd1);
    bus.flag_clr = 1'b1;
    step("brk_clr");
    check("brk_clr_val", 32'(bus.break_seen), 32'd0);
    bus.flag_clr      = 1'b1;
    bus.uart_rx_break = 1'b1;
    step("brk_set_wins");
    check("brk_set_wins_val", 32'(bus.break_seen), 32'd1);
    bus.flag_clr = 1'b1;
    step("brk_clr2");
    drain("brk_drain");

    // Seven bytes stored with overflow set, then asynchronous reset.
    for (int i = 0; i <= DEPTH; i++) push_byte("rst_fill", 8'(8'h90 + i));
    bus.fifo_ready = 1'b1;
    for (int i = 0; i < DEPTH - 7; i++) step("rst_pop");
    bus.fifo_ready = 1'b0;
    check("rst_pre_count", 32'(bus.fifo_count), 32'd7);
    check("rst_pre_ovf",   32'(bus.overflow),   32'd1);
    #2;
    resetn = 1'b0;
    #1;
    exp_q.delete();
    m_ovf = 1'b0;
    m_brk = 1'b0;
    check_state("async_rst");
    check("async_rst_data", 32'(bus.fifo_data), 32'h00);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    push_byte("post_rst", 8'h81);
    check("post_rst_data", 32'(bus.fifo_data), 32'h81);
    drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, meaning number of byte entries; SHALL be a power of two, 2..256.
REQ-002 Parameter CNT_W, default 5, meaning width of level count; SHALL equal log2(DEPTH)+1.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 uart_rx_valid  input  1  one-cycle strobe from the UART receiver marking a received byte.
REQ-006 uart_rx_data  input  8  received byte, qualified by uart_rx_valid.
REQ-007 uart_rx_break  input  1  one-cycle strobe from the UART receiver marking a BREAK condition.
REQ-008 fifo_ready  input  1  consumer accepts the head byte when fifo_valid is also high.
REQ-009 fifo_valid  output  1  high whenever the FIFO is not empty.
REQ-010 fifo_data  output  8  head byte, first-word-fall-through, stable while fifo_valid=1 and fifo_ready=0.
REQ-011 fifo_count  output  CNT_W  number of stored bytes, 0..DEPTH.
REQ-012 fifo_full  output  1  high when fifo_count==DEPTH.
REQ-013 overflow  output  1  sticky flag, byte dropped because FIFO full.
REQ-014 break_seen  output  1  sticky flag, BREAK received (macro-dependent, see Configuration).
REQ-015 flag_clr  input  1  one-cycle strobe clearing overflow and break_seen.

Function
REQ-016 Push: uart_rx_valid=1 and (fifo_full=0 or pop this cycle) SHALL write uart_rx_data at the write pointer and advance it.
REQ-017 Pop: fifo_valid=1 and fifo_ready=1 SHALL advance the read pointer; fifo_data SHALL show the next entry on the following cycle.
REQ-018 Latency: a byte pushed into an empty FIFO at edge N SHALL appear on fifo_data with fifo_valid=1 immediately after edge N.
REQ-019 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH without gaps.
REQ-020 Simultaneous push and pop SHALL leave fifo_count unchanged, including when full (write accepted) and when count==1.
REQ-021 Pop when empty SHALL be ignored (fifo_ready ignored while fifo_valid=0); push into empty with fifo_ready=1 SHALL NOT pop in the same cycle.
REQ-022 Push when full without simultaneous pop SHALL drop the byte, leave contents/pointers unchanged, and set overflow the next edge.
REQ-023 flag_clr SHALL clear overflow and break_seen; if a set event coincides with flag_clr, set SHALL win.
REQ-024 fifo_valid, fifo_full, fifo_count SHALL be derived from registered state only, no combinational path from uart_rx_valid.
REQ-025 uart_rx_data SHALL be ignored when uart_rx_valid=0.

Reset
REQ-026 resetn=0 SHALL asynchronously clear pointers, fifo_count=0, fifo_valid=0, fifo_full=0, overflow=0, break_seen=0; fifo_data SHALL read 8'h00.
REQ-027 Reset mid-operation SHALL discard all stored bytes; storage contents need not be cleared.
REQ-028 First push SHALL be accepted on the first rising edge after resetn deasserts.

Configuration
REQ-029 Macro UART_RX_FIFO_BREAK_FLUSH_EN: when defined, uart_rx_break=1 SHALL flush the FIFO (count 0, pointers equal) and set break_seen; a byte pushed in the same cycle SHALL be discarded.
REQ-030 Without UART_RX_FIFO_BREAK_FLUSH_EN: uart_rx_break SHALL only set break_seen; FIFO contents SHALL be unaffected.

Verification
REQ-031 Push 8'hA5, 8'h3C, 8'hFF with fifo_ready=0, then fifo_ready=1 -> fifo_data A5,3C,FF in order, fifo_count 3->0, fifo_valid low after last pop.
REQ-032 Push 17 bytes 8'h00..8'h10 with fifo_ready=0, DEPTH=16 -> fifo_full=1, overflow=1, drained data 00..0F, 8'h10 absent.
REQ-033 Fill to 16, then push 8'h55 with pop same cycle -> count stays 16, overflow=0, 8'h55 is last byte drained.
REQ-034 Stream 40 bytes with fifo_ready toggling every cycle -> all 40 bytes out in order, pointers wrap twice, no loss.
REQ-035 Store 5 bytes, pulse uart_rx_break -> with macro: count=0, break_seen=1; without: count=5, break_seen=1; flag_clr -> break_seen=0.
REQ-036 Assert resetn=0 with 7 bytes stored and overflow=1 -> all outputs at reset values asynchronously, next push 8'h81 read back correctly.
